// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 asynchronous serial receiver. rxd is brought into the clk domain by a
//   2-FF synchroniser. The receiver detects the start bit and samples every
//   bit at mid-bit. Each good byte is presented on data together with a
//   one-cycle valid strobe.
//
//   Optional feature: define UART_RX_PARITY_EN for 8E1 framing. An even
//   parity bit then follows the data bits, and a parity mismatch is reported
//   on ferr.
//
// Ports
//   clk    in   system clock, all logic on posedge
//   rst    in   asynchronous reset, active low
//   rxd    in   serial line, idle high, LSB first
//   data   out  last good byte, holds until the next good frame
//   valid  out  1-cycle pulse, data updated this cycle
//   ferr   out  1-cycle pulse, bad stop (or parity) bit, data not updated
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | confirming start bit at mid-bit
// DATA   | sampling 8 data bits, one per RATE clocks
// PARITY | sampling even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling stop bit at mid-bit
// BREAK  | framing error seen, waiting for line to return high
module uart_receiver #(
  parameter int CLK  = 50_000_000,
  parameter int BAUD = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       ferr
);

  localparam int RATE = CLK / BAUD;
  localparam int HALF = RATE / 2;
  localparam logic [31:0] HALF_TC = 32'(HALF - 1);
  localparam logic [31:0] RATE_TC = 32'(RATE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic        sync1, rx_s;
  logic [31:0] cnt;
  logic [2:0]  bitcnt;
  logic [7:0]  sh;
  logic        cnt_clr, shift_en, good, bad, par_ok;

`ifdef UART_RX_PARITY_EN
  logic        par, par_en;
  // even parity: data bits plus parity bit must have an even number of ones
  assign par_ok = ~^{sh, par};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
`endif
    case (state)
      IDLE:  if (!rx_s) state_nx = START;
      START: if (cnt == HALF_TC) state_nx = rx_s ? IDLE : DATA;
      DATA: if (cnt == RATE_TC) begin
        shift_en = 1'b1;
        cnt_clr  = 1'b1;
        if (bitcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_nx = PARITY;
`else
          state_nx = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == RATE_TC) begin
        par_en   = 1'b1;
        state_nx = STOP;
      end
`endif
      STOP: if (cnt == RATE_TC) begin
        // returning to IDLE at mid-stop leaves half a bit to catch a
        // back-to-back start bit
        if (rx_s && par_ok) begin
          good     = 1'b1;
          state_nx = IDLE;
        end else begin
          bad      = 1'b1;
          state_nx = BREAK;
        end
      end
      BREAK:   if (rx_s) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sh     <= '0;
      data   <= '0;
      valid  <= 1'b0;
      ferr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par    <= 1'b0;
`endif
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
      state <= state_nx;
      if (cnt_clr || (state_nx != state)) cnt <= '0;
      else                                cnt <= cnt + 32'd1;
      if ((state_nx == DATA) && (state != DATA)) bitcnt <= '0;
      else if (shift_en)                         bitcnt <= bitcnt + 3'd1;
      if (shift_en) sh <= {rx_s, sh[7:1]};
`ifdef UART_RX_PARITY_EN
      if (par_en) par <= rx_s;
`endif
      if (good) data <= sh;
      valid <= good;
      ferr  <= bad;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Scoreboard bench for uart_receiver at CLK=1 MHz, BAUD=100 kbit/s
//   (RATE=10, HALF=5). Every frame sent with good framing pushes its byte to
//   a queue. Each valid strobe pops one entry and compares it with data.
module tb_uart_receiver;

  localparam int RATE = 10;
  localparam int HALF = 5;
  localparam int LAT  = 2 + HALF + 9 * RATE + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] data;
  logic       valid, ferr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int fcnt     = 0;
  int vcyc     = 0;
  logic [7:0] expq[$];
  logic [7:0] last_good = 8'h00;

  uart_receiver #(.CLK(1_000_000), .BAUD(100_000)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid), .ferr(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (valid && ferr) chk("valid_and_ferr", 32'd1, 32'd0);
      if (valid) begin
        vcnt++;
        vcyc = cyc;
        if (expq.size() == 0) chk("unexpected_valid", {24'd0, data}, 32'hFFFF_FFFF);
        else begin
          last_good = expq.pop_front();
          chk("data", {24'd0, data}, {24'd0, last_good});
        end
      end
      if (ferr) fcnt++;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic p);
    rxd = 1'b0;
    wclk(RATE);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wclk(RATE);
    end
`ifdef UART_RX_PARITY_EN
    rxd = p;
    wclk(RATE);
`endif
    rxd = stop;
    wclk(RATE);
  endtask

  task automatic send_good(input logic [7:0] b);
    expq.push_back(b);
    send_frame(b, 1'b1, ^b);
  endtask

  int v0, f0, t0;

  initial begin
    // reset held with the line toggling
    for (int i = 0; i < 20; i++) begin
      rxd = i[0];
      @(negedge clk);
      chk("reset_out", {22'd0, data, valid, ferr}, 32'd0);
    end
    rxd = 1'b1;
    wclk(3);
    rst = 1'b1;
    wclk(20);

    // single byte with latency measurement
    v0 = vcnt; f0 = fcnt;
    wclk(1);
    t0 = cyc;
    send_good(8'hA5);
    wclk(3 * RATE);
    chk("a5_valid_cnt", vcnt - v0, 1);
    chk("a5_ferr_cnt", fcnt - f0, 0);
    chk("a5_latency_ok", ((vcyc - t0 >= LAT - 1) && (vcyc - t0 <= LAT + 1)) ? 1 : 0, 1);

    // back-to-back frames with minimal stop
    v0 = vcnt; f0 = fcnt;
    send_good(8'h55);
    send_good(8'h0F);
    send_good(8'hFF);
    wclk(3 * RATE);
    chk("b2b_valid_cnt", vcnt - v0, 3);
    chk("b2b_ferr_cnt", fcnt - f0, 0);

    // short glitch
    v0 = vcnt; f0 = fcnt;
    rxd = 1'b0;
    wclk(3);
    rxd = 1'b1;
    wclk(3 * RATE);
    chk("glitch_valid_cnt", vcnt - v0, 0);
    chk("glitch_ferr_cnt", fcnt - f0, 0);

    // bad stop followed by a long break
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wclk(30 * RATE);
    rxd = 1'b1;
    wclk(3 * RATE);
    chk("break_ferr_cnt", fcnt - f0, 1);
    chk("break_valid_cnt", vcnt - v0, 0);
    chk("break_data_hold", {24'd0, data}, 32'h0000_00FF);
    send_good(8'h81);
    wclk(3 * RATE);
    chk("after_break_valid", vcnt - v0, 1);
    chk("after_break_data", {24'd0, data}, 32'h0000_0081);

    // reset in the middle of 0xC3
    v0 = vcnt; f0 = fcnt;
    rxd = 1'b0;
    wclk(RATE);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'hC3 >> i) & 8'h01;
      wclk(RATE);
    end
    rst = 1'b0;
    wclk(5);
    rxd = 1'b1;
    chk("midreset_data", {24'd0, data}, 32'd0);
    rst = 1'b1;
    wclk(2 * RATE);
    send_good(8'h12);
    wclk(3 * RATE);
    chk("midreset_valid_cnt", vcnt - v0, 1);
    chk("midreset_ferr_cnt", fcnt - f0, 0);
    chk("midreset_data_final", {24'd0, data}, 32'h0000_0012);

`ifdef UART_RX_PARITY_EN
    v0 = vcnt; f0 = fcnt;
    expq.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wclk(3 * RATE);
    chk("par_good_valid", vcnt - v0, 1);
    chk("par_good_data", {24'd0, data}, 32'h0000_0007);
    v0 = vcnt;
    send_frame(8'h07, 1'b1, 1'b0);
    wclk(3 * RATE);
    chk("par_bad_ferr", fcnt - f0, 1);
    chk("par_bad_valid", vcnt - v0, 0);
    chk("par_bad_data", {24'd0, data}, 32'h0000_0007);
`endif

    chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
